// File: rtl/jtkicker_obj_pkg.sv
// Shared definitions for the Kicker/Track object scanner family.
//   - obj_state_e : scanner FSM state encoding
//   - ATTR_*      : bit positions inside the object attribute byte
//   - objh_bits() : number of ysub bits needed for a given sprite height
package jtkicker_obj_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCROLL = 3'd1,
        ST_ATTR   = 3'd2,
        ST_POS    = 3'd3,
        ST_CHECK  = 3'd4,
        ST_ISSUE  = 3'd5,
        ST_NEXT   = 3'd6
    } obj_state_e;

    localparam int ATTR_PAL    = 0;
    localparam int ATTR_PALW   = 4;
    localparam int ATTR_CODEHI = 4;
    localparam int ATTR_HFLIP  = 6;
    localparam int ATTR_VFLIP  = 7;

    // Sprite heights are 8, 16 or 32 lines.
    function automatic int objh_bits(input int objh);
        if (objh <= 32'sd8) begin
            return 3;
        end else if (objh <= 32'sd16) begin
            return 4;
        end else begin
            return 5;
        end
    endfunction

endpackage

// File: rtl/jtkicker_objzone.sv
// Vertical zone test for one object against the current line.
//   vdf    in  8        : line number, already flip-adjusted
//   ypos   in  8        : raw object Y byte from the table
//   inzone out 1        : object covers this line
//   ysub   out log2(OBJH): line within the sprite
// Purely combinational; the caller registers the results.
module jtkicker_objzone
    import jtkicker_obj_pkg::*;
#(
    parameter int          OBJH = 16,
    parameter logic [7:0]  YADJ = 8'd0
) (
    input  logic [7:0]                   vdf,
    input  logic [7:0]                   ypos,
    output logic                         inzone,
    output logic [objh_bits(OBJH)-1:0]   ysub
);
    localparam int YW = objh_bits(OBJH);

    logic [7:0] dr_y_s;
    logic [7:0] ydiff_s;

    // Object top line and distance from it, both wrapping in 8 bits.
    always_comb begin
        dr_y_s  = ~ypos + YADJ;
        ydiff_s = vdf - dr_y_s;
        inzone  = ({1'b0, ydiff_s} < 9'(OBJH));
        ysub    = ydiff_s[YW-1:0];
    end

endmodule

// File: rtl/jtkicker_objscan.sv
// Per-line object table scanner for the Kicker/Track sprite hardware.
// On hinit it optionally fetches a row-scroll word, then walks objects from
// MAXOBJ-1 down to 0 and issues one draw request per object covering the
// current line. Optional per-line sprite limit raises ovf and ends the scan.
// Row scroll fetch is built only when JTKICKER_OBJ_ROWSCR_EN is defined;
// otherwise hpos stays 0 and the scan starts straight at the first object.
// Ports:
//   clk, rst (sync, active-high), cen2 (scan enable), hinit (line start),
//   vdump[8:0], flip          : line timing inputs
//   scan_addr[AW-1:0] out, lo_data/hi_data in : object table RAM port
//   hpos[8:0] out             : row scroll value
//   draw out, busy in         : drawer handshake
//   code, xpos, pal, hflip, vflip, ysub out : drawer parameters
//   ovf out                   : sprite limit reached on this line
module jtkicker_objscan
    import jtkicker_obj_pkg::*;
#(
    parameter int              MAXOBJ   = 24,
    parameter int              AW       = 7,
    parameter int              OBJH     = 16,
    parameter int              CODEW    = 9,
    parameter logic [7:0]      YADJ     = 8'd0,
    parameter int              MAXLINE  = 0,
    parameter logic [AW-1:0]   SCR_BASE = 7'h40
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cen2,
    input  logic                        hinit,
    input  logic [8:0]                  vdump,
    input  logic                        flip,
    output logic [AW-1:0]               scan_addr,
    input  logic [7:0]                  lo_data,
    input  logic [7:0]                  hi_data,
    output logic [8:0]                  hpos,
    output logic                        draw,
    input  logic                        busy,
    output logic [CODEW-1:0]            code,
    output logic [7:0]                  xpos,
    output logic [3:0]                  pal,
    output logic                        hflip,
    output logic                        vflip,
    output logic [objh_bits(OBJH)-1:0]  ysub,
    output logic                        ovf
);
    localparam int              YW         = objh_bits(OBJH);
    localparam logic [AW-1:0]   FIRST_ADDR = AW'((MAXOBJ - 32'sd1) * 32'sd2);
    localparam logic [AW-1:0]   ADDR_STEP  = AW'(32'd2);

    obj_state_e     st_r, st_s;
    logic           pend_r, pend_s;
    logic [AW-1:0]  addr_r, addr_s;
    logic [7:0]     attr_r, attr_s;
    logic [7:0]     code_lo_r, code_lo_s;
    logic [7:0]     ypos_r, ypos_s;
    logic [7:0]     xpos_r, xpos_s;
    logic [8:0]     hpos_r, hpos_s;
    logic           draw_r, draw_s;
    logic           ovf_r, ovf_s;
    logic           zone_r, zone_s;
    logic           last_r, last_s;
    logic [YW-1:0]  ysub_r, ysub_s;
    logic [6:0]     cnt_r, cnt_s;

    logic [7:0]     vdf_s;
    logic           zone_c;
    logic [YW-1:0]  ysub_c;
    logic           abort_s;
    logic           count_s;
    logic           unused_s;

    assign vdf_s   = vdump[7:0] ^ {8{flip}};
    // A new line request while scanning cancels the current scan.
    assign abort_s = cen2 && pend_r && (st_r != ST_IDLE);
    assign count_s = zone_r && !ovf_r && (MAXLINE > 32'sd0);
    assign unused_s = ^{vdump[8], attr_r[5], SCR_BASE};

    jtkicker_objzone #(
        .OBJH (OBJH),
        .YADJ (YADJ)
    ) u_zone (
        .vdf    (vdf_s),
        .ypos   (ypos_r),
        .inzone (zone_c),
        .ysub   (ysub_c)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_r <= ST_IDLE;
        end else begin
            st_r <= st_s;
        end
    end

    // FSM next-state logic, advancing only on cen2.
    always_comb begin
        st_s = st_r;
        if (!cen2) begin
            st_s = st_r;
        end else if (abort_s) begin
            st_s = ST_IDLE;
        end else begin
            case (st_r)
                ST_IDLE: begin
                    if (pend_r) begin
`ifdef JTKICKER_OBJ_ROWSCR_EN
                        st_s = ST_SCROLL;
`else
                        st_s = ST_ATTR;
`endif
                    end else begin
                        st_s = ST_IDLE;
                    end
                end
                ST_SCROLL: st_s = ST_ATTR;
                ST_ATTR:   st_s = busy ? ST_ATTR : ST_POS;
                ST_POS:    st_s = ST_CHECK;
                ST_CHECK:  st_s = ST_ISSUE;
                ST_ISSUE:  st_s = ST_NEXT;
                ST_NEXT:   st_s = (last_r || ovf_r) ? ST_IDLE : ST_ATTR;
                default:   st_s = ST_IDLE;
            endcase
        end
    end

    // Next values of the datapath and output registers.
    always_comb begin
        pend_s    = pend_r;
        addr_s    = addr_r;
        attr_s    = attr_r;
        code_lo_s = code_lo_r;
        ypos_s    = ypos_r;
        xpos_s    = xpos_r;
        hpos_s    = hpos_r;
        draw_s    = draw_r;
        ovf_s     = ovf_r;
        zone_s    = zone_r;
        last_s    = last_r;
        ysub_s    = ysub_r;
        cnt_s     = cnt_r;

        // hinit wins over consumption so a pulse on the consuming tick is kept.
        if (hinit) begin
            pend_s = 1'b1;
        end else if (cen2 && (st_r == ST_IDLE)) begin
            pend_s = 1'b0;
        end else begin
            pend_s = pend_r;
        end

        if (!cen2) begin
            draw_s = draw_r;
        end else if (abort_s) begin
            draw_s = 1'b0;
        end else begin
            case (st_r)
                ST_IDLE: begin
                    if (pend_r) begin
`ifdef JTKICKER_OBJ_ROWSCR_EN
                        addr_s = SCR_BASE + AW'(vdf_s[7:3]);
`else
                        addr_s = FIRST_ADDR;
                        cnt_s  = 7'd0;
                        ovf_s  = 1'b0;
`endif
                    end else begin
                        addr_s = addr_r;
                    end
                end
                ST_SCROLL: begin
`ifdef JTKICKER_OBJ_ROWSCR_EN
                    hpos_s = {hi_data[7], lo_data};
`endif
                    addr_s = FIRST_ADDR;
                    cnt_s  = 7'd0;
                    ovf_s  = 1'b0;
                end
                ST_ATTR: begin
                    if (!busy) begin
                        attr_s    = lo_data;
                        code_lo_s = hi_data;
                        addr_s    = {addr_r[AW-1:1], 1'b1};
                    end else begin
                        attr_s = attr_r;
                    end
                end
                ST_POS: begin
                    ypos_s = lo_data;
                    xpos_s = hi_data;
                end
                ST_CHECK: begin
                    zone_s = zone_c;
                    ysub_s = ysub_c;
                end
                ST_ISSUE: begin
                    draw_s = zone_r && !ovf_r;
                    addr_s = {addr_r[AW-1:1], 1'b0} - ADDR_STEP;
                    last_s = (addr_r[AW-1:1] == {(AW-1){1'b0}});
                    if (count_s) begin
                        cnt_s = cnt_r + 7'd1;
                        if ((cnt_r + 7'd1) == 7'(MAXLINE)) begin
                            ovf_s = 1'b1;
                        end else begin
                            ovf_s = ovf_r;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_NEXT: draw_s = 1'b0;
                default: draw_s = 1'b0;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r    <= 1'b0;
            addr_r    <= {AW{1'b0}};
            attr_r    <= 8'd0;
            code_lo_r <= 8'd0;
            ypos_r    <= 8'd0;
            xpos_r    <= 8'd0;
            hpos_r    <= 9'd0;
            draw_r    <= 1'b0;
            ovf_r     <= 1'b0;
            zone_r    <= 1'b0;
            last_r    <= 1'b0;
            ysub_r    <= {YW{1'b0}};
            cnt_r     <= 7'd0;
        end else begin
            pend_r    <= pend_s;
            addr_r    <= addr_s;
            attr_r    <= attr_s;
            code_lo_r <= code_lo_s;
            ypos_r    <= ypos_s;
            xpos_r    <= xpos_s;
            hpos_r    <= hpos_s;
            draw_r    <= draw_s;
            ovf_r     <= ovf_s;
            zone_r    <= zone_s;
            last_r    <= last_s;
            ysub_r    <= ysub_s;
            cnt_r     <= cnt_s;
        end
    end

    generate
        if (CODEW > 8) begin : g_codehi
            assign code = {attr_r[ATTR_CODEHI +: CODEW-8], code_lo_r};
        end else begin : g_code8
            assign code = code_lo_r;
        end
    endgenerate

    assign scan_addr = addr_r;
    assign hpos      = hpos_r;
    assign draw      = draw_r;
    assign xpos      = xpos_r;
    assign pal       = attr_r[ATTR_PAL +: ATTR_PALW];
    assign hflip     = attr_r[ATTR_HFLIP];
    assign vflip     = attr_r[ATTR_VFLIP];
    assign ysub      = ysub_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_jtkicker_objscan.sv
module tb_jtkicker_objscan;

    logic       clk = 1'b0;
    logic       cen2 = 1'b0;
    logic       rst;
    logic       hinit;
    logic [8:0] vdump;
    logic       flip;
    logic       busy = 1'b0;
    logic       busy2 = 1'b0;

    logic [6:0] scan_addr, scan_addr2;
    logic [7:0] lo_data, hi_data, lo_data2, hi_data2;
    logic [8:0] hpos, hpos2;
    logic       draw, draw2;
    logic [8:0] code, code2;
    logic [7:0] xpos, xpos2;
    logic [3:0] pal, pal2;
    logic       hflip, hflip2, vflip, vflip2;
    logic [3:0] ysub, ysub2;
    logic       ovf, ovf2;

    logic [7:0] ram_lo [0:127];
    logic [7:0] ram_hi [0:127];

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];
    int  busy_mode = 0;
    int  busy_cnt  = 0;
    int  draw2_cnt = 0;
    logic [8:0] last_code = 9'd0;
    logic [8:0] exp_hpos;

    jtkicker_objscan dut (
        .clk(clk), .rst(rst), .cen2(cen2), .hinit(hinit), .vdump(vdump), .flip(flip),
        .scan_addr(scan_addr), .lo_data(lo_data), .hi_data(hi_data), .hpos(hpos),
        .draw(draw), .busy(busy), .code(code), .xpos(xpos), .pal(pal),
        .hflip(hflip), .vflip(vflip), .ysub(ysub), .ovf(ovf)
    );

    jtkicker_objscan #(.MAXLINE(2)) dut2 (
        .clk(clk), .rst(rst), .cen2(cen2), .hinit(hinit), .vdump(vdump), .flip(flip),
        .scan_addr(scan_addr2), .lo_data(lo_data2), .hi_data(hi_data2), .hpos(hpos2),
        .draw(draw2), .busy(busy2), .code(code2), .xpos(xpos2), .pal(pal2),
        .hflip(hflip2), .vflip(vflip2), .ysub(ysub2), .ovf(ovf2)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(negedge clk);
        cen2 = ~cen2;
    end

    // Table RAM: registered read every clk, data ready by the next cen2 tick.
    always @(posedge clk) begin
        lo_data  <= ram_lo[scan_addr];
        hi_data  <= ram_hi[scan_addr];
        lo_data2 <= ram_lo[scan_addr2];
        hi_data2 <= ram_hi[scan_addr2];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [8:0] c, input logic [7:0] x,
                                         input logic [3:0] p, input logic hf,
                                         input logic vf, input logic [3:0] ys);
        return {5'd0, c, x, p, hf, vf, ys};
    endfunction

    task automatic set_obj(input int n, input logic [7:0] attr, input logic [7:0] clo,
                           input logic [7:0] yp, input logic [7:0] xp);
        ram_lo[2*n]   = attr;
        ram_hi[2*n]   = clo;
        ram_lo[2*n+1] = yp;
        ram_hi[2*n+1] = xp;
    endtask

    task automatic push(input logic [7:0] attr, input logic [7:0] clo,
                        input logic [7:0] xp, input logic [3:0] ys);
        exp_q.push_back(pack({attr[4], clo}, xp, attr[3:0], attr[6], attr[7], ys));
    endtask

    task automatic pulse_hinit();
        @(negedge clk);
        hinit = 1'b1;
        @(negedge clk);
        hinit = 1'b0;
    endtask

    task automatic run_line(input int ticks);
        pulse_hinit();
        repeat (ticks * 2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_draw();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (draw) begin
                found = 1'b1;
                break;
            end
        end
        check("draw_seen", {31'd0, found}, 32'd1);
    endtask

    // Monitor: scoreboard pop on draw, pulse width, busy model, dut2 counting.
    initial begin
        logic        draw_q, draw2_q;
        int          width;
        logic [31:0] e;
        draw_q = 1'b0; draw2_q = 1'b0; width = 0;
        forever begin
            @(negedge clk);
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    busy = 1'b0;
                    check("busy_hold_code", {23'd0, code}, {23'd0, last_code});
                end
            end
            if (draw && !draw_q) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = 32'hFFFF_FFFF;
                check("draw_fields", pack(code, xpos, pal, hflip, vflip, ysub), e);
                last_code = e[26:18];
                if (busy_mode != 0) begin
                    busy = 1'b1;
                    busy_cnt = 40;
                end
                width = 0;
            end
            if (draw) width++;
            if (!draw && draw_q) check("draw_width", width, 2);
            draw_q = draw;
            if (draw2 && !draw2_q) draw2_cnt++;
            draw2_q = draw2;
        end
    end

    initial begin
        int snap;
`ifdef JTKICKER_OBJ_ROWSCR_EN
        exp_hpos = 9'h134;
`else
        exp_hpos = 9'h000;
`endif
        rst = 1'b1; hinit = 1'b0; vdump = 9'd0; flip = 1'b0;
        for (int i = 0; i < 128; i++) begin
            ram_lo[i] = 8'h00;
            ram_hi[i] = 8'h00;
        end
        for (int n = 0; n < 24; n++) set_obj(n, 8'h00, 8'h00, 8'h37, 8'h00);
        ram_lo[7'h45] = 8'h34;
        ram_hi[7'h45] = 8'h80;

        repeat (6) @(negedge clk);
        check("rst_draw", {31'd0, draw}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_hpos", {23'd0, hpos}, 32'd0);
        check("rst_addr", {25'd0, scan_addr}, 32'd0);
        check("rst_code", {23'd0, code}, 32'd0);
        check("rst_xpos", {24'd0, xpos}, 32'd0);
        check("rst_pal", {28'd0, pal}, 32'd0);
        check("rst_ysub", {28'd0, ysub}, 32'd0);
        check("rst_ovf2", {31'd0, ovf2}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single object in zone, ysub 5.
        set_obj(5, 8'h53, 8'hA7, 8'hD7, 8'h88);
        vdump = 9'd45;
        push(8'h53, 8'hA7, 8'h88, 4'd5);
        run_line(200);
        check("hpos_rowscroll", {23'd0, hpos}, {23'd0, exp_hpos});
        check("single_ovf2", {31'd0, ovf2}, 32'd0);

        // Line just past the sprite bottom: no draw.
        vdump = 9'd56;
        run_line(200);

        // Flipped screen maps back to line 45.
        flip = 1'b1;
        vdump = {1'b0, ~8'd45};
        push(8'h53, 8'hA7, 8'h88, 4'd5);
        run_line(200);
        flip = 1'b0;

        // Three objects, drawer busy 20 ticks after each draw.
        set_obj(5, 8'h00, 8'h00, 8'h37, 8'h00);
        set_obj(3, 8'h8A, 8'h33, 8'hD7, 8'h10);
        set_obj(2, 8'h15, 8'h44, 8'hD3, 8'h20);
        set_obj(1, 8'h40, 8'h11, 8'hE1, 8'h30);
        vdump = 9'd45;
        busy_mode = 1;
        push(8'h8A, 8'h33, 8'h10, 4'd5);
        push(8'h15, 8'h44, 8'h20, 4'd1);
        push(8'h40, 8'h11, 8'h30, 4'd15);
        run_line(300);
        busy_mode = 0;

        // Four objects: unlimited instance draws all, limited one stops at 2.
        set_obj(4, 8'hC7, 8'h04, 8'hD7, 8'h40);
        push(8'hC7, 8'h04, 8'h40, 4'd5);
        push(8'h8A, 8'h33, 8'h10, 4'd5);
        push(8'h15, 8'h44, 8'h20, 4'd1);
        push(8'h40, 8'h11, 8'h30, 4'd15);
        snap = draw2_cnt;
        run_line(200);
        check("limit_draws", draw2_cnt - snap, 2);
        check("limit_ovf", {31'd0, ovf2}, 32'd1);
        check("nolimit_ovf", {31'd0, ovf}, 32'd0);

        // Empty line clears ovf on its scan start.
        vdump = 9'd100;
        run_line(200);
        check("ovf_cleared", {31'd0, ovf2}, 32'd0);

        // hinit while object 3 is in CHECK: abort, restart from the top.
        vdump = 9'd45;
        push(8'hC7, 8'h04, 8'h40, 4'd5);
        push(8'hC7, 8'h04, 8'h40, 4'd5);
        push(8'h8A, 8'h33, 8'h10, 4'd5);
        push(8'h15, 8'h44, 8'h20, 4'd1);
        push(8'h40, 8'h11, 8'h30, 4'd15);
        pulse_hinit();
        wait_draw();
        repeat (6) @(negedge clk);
        hinit = 1'b1;
        @(negedge clk);
        hinit = 1'b0;
        repeat (600) @(negedge clk);
        check("abort_drained", exp_q.size(), 0);

        // Reset on object 3's ISSUE tick: no draw, FSM idles.
        push(8'hC7, 8'h04, 8'h40, 4'd5);
        pulse_hinit();
        wait_draw();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_issue_draw", {31'd0, draw}, 32'd0);
        repeat (400) @(negedge clk);
        check("rst_drained", exp_q.size(), 0);
        check("rst_idle_addr", {25'd0, scan_addr}, 32'd0);
        check("rst_idle_draw", {31'd0, draw}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
